// File: rtl/vctr_result_reduce_pkg.sv
// Shared types for the vector result reduction stage.
package vctr_result_reduce_pkg;

    localparam int DEF_DATA_WIDTH      = 16;
    localparam int DEF_HSP_BANDS_WIDTH = 3;

    typedef enum logic [1:0] {
        RR_IDLE,
        RR_DRAIN,
        RR_FLUSH,
        RR_RESULT
    } rr_state_t;

endpackage

// File: rtl/vctr_result_reduce_if.sv
// Result record handshake toward the distance/classification logic.
interface vctr_result_reduce_if
    import vctr_result_reduce_pkg::*;
#(
    parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
    parameter int HSP_BANDS_WIDTH = DEF_HSP_BANDS_WIDTH,
    parameter int ACC_WIDTH       = DATA_WIDTH + HSP_BANDS_WIDTH
);
    logic                       res_valid;
    logic                       res_ready;
    logic [ACC_WIDTH-1:0]       res_sum;
    logic [DATA_WIDTH-1:0]      res_max;
    logic [HSP_BANDS_WIDTH-1:0] res_max_idx;

    modport master (
        output res_valid,
        output res_sum,
        output res_max,
        output res_max_idx,
        input  res_ready
    );

    modport slave (
        input  res_valid,
        input  res_sum,
        input  res_max,
        input  res_max_idx,
        output res_ready
    );
endinterface

// File: rtl/vctr_result_reduce.sv
// Drains one full vector from the upstream registered-read FIFO and reduces it
// to sum, maximum value and index of the (first) maximum.
module vctr_result_reduce
    import vctr_result_reduce_pkg::*;
#(
    parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
    parameter int HSP_BANDS_WIDTH = DEF_HSP_BANDS_WIDTH,
    parameter int ACC_WIDTH       = DATA_WIDTH + HSP_BANDS_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   src_done,
    output logic                   src_rd_en,
    input  logic [DATA_WIDTH-1:0]  src_data,
    vctr_result_reduce_if.master   res,
    output logic                   idle,
    output logic                   err_underrun
);

    // Counters carry one extra bit so they can hold NUM_BANDS itself.
    localparam int             CNT_W       = HSP_BANDS_WIDTH + 1;
    localparam logic [CNT_W-1:0] NUM_BANDS_C = CNT_W'(1 << HSP_BANDS_WIDTH);
    localparam logic [CNT_W-1:0] LAST_RD     = CNT_W'((1 << HSP_BANDS_WIDTH) - 1);

    rr_state_t                  state_q, state_d;
    logic [CNT_W-1:0]           rd_cnt_q;
    logic [CNT_W-1:0]           cap_cnt_q;
    logic                       cap_v_q;
    logic [ACC_WIDTH-1:0]       acc_q;
    logic [DATA_WIDTH-1:0]      max_q;
    logic [HSP_BANDS_WIDTH-1:0] max_idx_q;
    logic                       armed_q;
    logic                       err_q;
    logic [ACC_WIDTH-1:0]       res_sum_q;
    logic [DATA_WIDTH-1:0]      res_max_q;
    logic [HSP_BANDS_WIDTH-1:0] res_max_idx_q;

    logic start;
    logic underrun;
    logic load_res;
    logic res_valid_c;

    // State register.
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk) begin
        if (rst) state_q <= RR_IDLE;
        else     state_q <= state_d;
    end

    // Next-state and per-state control strobes.
    // NOTE: every output of this block gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        src_rd_en   = 1'b0;
        idle        = 1'b0;
        res_valid_c = 1'b0;
        start       = 1'b0;
        underrun    = 1'b0;
        load_res    = 1'b0;
        case (state_q)
            RR_IDLE: begin
                idle = 1'b1;
                // armed_q blocks re-triggering on a done that is still high
                // from the vector just delivered.
                if (src_done && armed_q) begin
                    start   = 1'b1;
                    state_d = RR_DRAIN;
                end
            end
            RR_DRAIN: begin
                src_rd_en = (rd_cnt_q < NUM_BANDS_C);
                if (!src_done) begin
                    underrun = 1'b1;
                    state_d  = RR_IDLE;
                end else if (rd_cnt_q == LAST_RD) begin
                    state_d = RR_FLUSH;
                end
            end
            RR_FLUSH: begin
                // Wait until the read data of the last strobe has been folded in.
                if (!cap_v_q) begin
                    load_res = 1'b1;
                    state_d  = RR_RESULT;
                end
            end
            RR_RESULT: begin
                res_valid_c = 1'b1;
                if (res.res_ready) state_d = RR_IDLE;
            end
            default: state_d = RR_IDLE;
        endcase
    end

    // Read counter, re-arm tracking and sticky underrun flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_cnt_q <= '0;
            armed_q  <= 1'b1;
            err_q    <= 1'b0;
        end else begin
            if (start)          rd_cnt_q <= '0;
            else if (src_rd_en) rd_cnt_q <= rd_cnt_q + 1'b1;

            if (underrun) err_q <= 1'b1;

            if (state_q == RR_RESULT && res.res_ready)  armed_q <= 1'b0;
            else if (state_q == RR_IDLE && !src_done)   armed_q <= 1'b1;
        end
    end

    // Capture pipeline: data arrives one cycle after its strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            cap_v_q   <= 1'b0;
            cap_cnt_q <= '0;
            acc_q     <= '0;
            max_q     <= '0;
            max_idx_q <= '0;
        end else begin
            cap_v_q <= src_rd_en;
            if (start) begin
                cap_cnt_q <= '0;
                acc_q     <= '0;
                max_q     <= '0;
                max_idx_q <= '0;
            end else if (cap_v_q) begin
                cap_cnt_q <= cap_cnt_q + 1'b1;
                acc_q     <= acc_q + ACC_WIDTH'(src_data);
                // Strict compare keeps the lowest index on ties.
                if (cap_cnt_q == '0 || src_data > max_q) begin
                    max_q     <= src_data;
                    max_idx_q <= cap_cnt_q[HSP_BANDS_WIDTH-1:0];
                end
            end
        end
    end

    // Result record registers, held stable while presented.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_sum_q     <= '0;
            res_max_q     <= '0;
            res_max_idx_q <= '0;
        end else if (load_res) begin
            res_sum_q     <= acc_q;
            res_max_q     <= max_q;
            res_max_idx_q <= max_idx_q;
        end
    end

    assign res.res_valid   = res_valid_c;
    assign res.res_sum     = res_sum_q;
    assign res.res_max     = res_max_q;
    assign res.res_max_idx = res_max_idx_q;
    assign err_underrun    = err_q;

endmodule

// File: tb/tb_vctr_result_reduce.sv
// Scoreboard bench for vctr_result_reduce with a registered-read FIFO model.
module tb_vctr_result_reduce;

    localparam int DW = 16;
    localparam int BW = 3;
    localparam int NB = 8;
    localparam int AW = DW + BW;

    typedef struct {
        logic [AW-1:0] sum;
        logic [DW-1:0] mx;
        logic [BW-1:0] idx;
    } rec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          src_done = 1'b0;
    logic          src_rd_en;
    logic [DW-1:0] src_data = '0;
    logic          res_ready = 1'b1;
    logic          idle;
    logic          err_underrun;

    int total = 0;
    int bad = 0;
    int strobes = 0;
    int records = 0;

    logic [DW-1:0] fifo[$];
    rec_t          exp_q[$];
    logic [DW-1:0] vec[NB];
    bit            auto_drop = 1'b1;
    bit            rand_ready = 1'b0;

    vctr_result_reduce_if #(.DATA_WIDTH(DW), .HSP_BANDS_WIDTH(BW)) res_if();
    assign res_if.res_ready = res_ready;

    vctr_result_reduce #(.DATA_WIDTH(DW), .HSP_BANDS_WIDTH(BW)) dut (
        .clk          (clk),
        .rst          (rst),
        .src_done     (src_done),
        .src_rd_en    (src_rd_en),
        .src_data     (src_data),
        .res          (res_if),
        .idle         (idle),
        .err_underrun (err_underrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain sum, first occurrence of the largest value.
    function automatic rec_t model();
        rec_t r;
        int   s = 0;
        r.mx  = vec[0];
        r.idx = '0;
        for (int i = 0; i < NB; i++) begin
            s += int'(vec[i]);
            if (vec[i] > r.mx) begin
                r.mx  = vec[i];
                r.idx = BW'(i);
            end
        end
        r.sum = AW'(s);
        return r;
    endfunction

    task automatic load_fifo();
        for (int i = 0; i < NB; i++) fifo.push_back(vec[i]);
    endtask

    task automatic wait_records(input int n, input int budget);
        int c = 0;
        while (records < n && c < budget) begin
            tick();
            c++;
        end
        check("record arrival", records, n);
    endtask

    // Full vector: preload FIFO, push expectation, raise done, await record.
    task automatic run_vec(input string tag);
        int s0 = strobes;
        int target = records + 1;
        load_fifo();
        exp_q.push_back(model());
        src_done = 1'b1;
        wait_records(target, 300);
        check({tag, " strobes"}, strobes - s0, NB);
        tick();
        tick();
    endtask

    // Upstream FIFO: a strobe in cycle N presents the word in cycle N+1.
    initial begin
        logic [DW-1:0] nxt;
        bit            empty_now;
        forever begin
            @(negedge clk);
            if (src_rd_en === 1'b1) begin
                strobes++;
                nxt = (fifo.size() > 0) ? fifo.pop_front() : '0;
                empty_now = (fifo.size() == 0);
                @(posedge clk);
                #1;
                src_data = nxt;
                if (empty_now && auto_drop) src_done = 1'b0;
            end
        end
    end

    // Random consumer back-pressure.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) res_ready = 1'($urandom_range(0, 1));
        end
    end

    // Monitor: compare every accepted record against the scoreboard.
    initial begin
        rec_t e;
        forever begin
            @(negedge clk);
            if (res_if.res_valid === 1'b1 && res_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected record", 32'(res_if.res_valid), 0);
                end else begin
                    e = exp_q.pop_front();
                    check("res_sum", 32'(res_if.res_sum), 32'(e.sum));
                    check("res_max", 32'(res_if.res_max), 32'(e.mx));
                    check("res_max_idx", 32'(res_if.res_max_idx), 32'(e.idx));
                end
                records++;
            end
        end
    end

    initial begin
        int s0;
        int lat;
        int held;

        // Reset state.
        tick();
        tick();
        @(negedge clk);
        check("rst idle", 32'(idle), 1);
        check("rst src_rd_en", 32'(src_rd_en), 0);
        check("rst res_valid", 32'(res_if.res_valid), 0);
        check("rst res_sum", 32'(res_if.res_sum), 0);
        check("rst res_max", 32'(res_if.res_max), 0);
        check("rst res_max_idx", 32'(res_if.res_max_idx), 0);
        check("rst err_underrun", 32'(err_underrun), 0);
        tick();
        rst = 1'b0;
        tick();

        // 1: ascending vector, done held high throughout, latency and no re-trigger.
        auto_drop = 1'b0;
        for (int i = 0; i < NB; i++) vec[i] = DW'(i + 1);
        load_fifo();
        exp_q.push_back(model());
        s0 = strobes;
        src_done = 1'b1;
        lat = 0;
        while (res_if.res_valid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("t1 valid latency", lat, 12);
        @(negedge clk);
        check("t1 single-cycle valid", 32'(res_if.res_valid), 0);
        repeat (6) tick();
        check("t1 strobes", strobes - s0, NB);
        check("t1 idle while done high", 32'(idle), 1);
        check("t1 records", records, 1);
        src_done = 1'b0;
        auto_drop = 1'b1;
        tick();
        tick();

        // 2: consumer stalls for 20 cycles.
        res_ready = 1'b0;
        vec = '{16'd9, 16'd3, 16'd9, 16'd0, 16'd0, 16'd0, 16'd0, 16'd1};
        load_fifo();
        exp_q.push_back(model());
        s0 = strobes;
        src_done = 1'b1;
        lat = 0;
        while (res_if.res_valid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        held = 0;
        repeat (20) begin
            @(negedge clk);
            if (res_if.res_valid === 1'b1) held++;
        end
        check("t2 valid held", held, 20);
        check("t2 strobes", strobes - s0, NB);
        tick();
        res_ready = 1'b1;
        wait_records(2, 20);
        tick();
        tick();

        // 3: all-max vector, sum must not wrap.
        for (int i = 0; i < NB; i++) vec[i] = 16'hFFFF;
        run_vec("t3");

        // 4: done falls after 5 strobes.
        for (int i = 0; i < NB; i++) vec[i] = DW'(i + 100);
        load_fifo();
        s0 = strobes;
        held = records;
        src_done = 1'b1;
        repeat (5) tick();
        src_done = 1'b0;
        tick();
        @(negedge clk);
        check("t4 err_underrun", 32'(err_underrun), 1);
        check("t4 idle", 32'(idle), 1);
        repeat (10) tick();
        check("t4 strobes", strobes - s0, 5);
        check("t4 no record", records, held);
        fifo.delete();

        // 5: reset mid-drain after 3 strobes.
        for (int i = 0; i < NB; i++) vec[i] = DW'(i + 50);
        load_fifo();
        s0 = strobes;
        src_done = 1'b1;
        repeat (3) tick();
        rst = 1'b1;
        src_done = 1'b0;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("t5 src_rd_en", 32'(src_rd_en), 0);
        check("t5 res_valid", 32'(res_if.res_valid), 0);
        check("t5 idle", 32'(idle), 1);
        check("t5 res_sum", 32'(res_if.res_sum), 0);
        check("t5 res_max", 32'(res_if.res_max), 0);
        check("t5 res_max_idx", 32'(res_if.res_max_idx), 0);
        check("t5 err cleared", 32'(err_underrun), 0);
        check("t5 strobes", strobes - s0, 3);
        tick();
        fifo.delete();
        tick();

        // 6: two vectors back to back.
        s0 = strobes;
        for (int i = 0; i < NB; i++) vec[i] = DW'(i + 1);
        run_vec("t6a");
        for (int i = 0; i < NB; i++) vec[i] = 16'd2;
        run_vec("t6b");
        check("t6 total strobes", strobes - s0, 2 * NB);

        // Randomized vectors with random back-pressure.
        rand_ready = 1'b1;
        for (int n = 0; n < 20; n++) begin
            for (int i = 0; i < NB; i++) begin
                if (n % 3 == 0) vec[i] = DW'($urandom_range(0, 3));
                else            vec[i] = DW'($urandom);
            end
            run_vec("rand");
        end
        rand_ready = 1'b0;
        res_ready = 1'b1;

        repeat (3) tick();
        check("scoreboard drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
